dm_responder: RTL



---
 rtl/dm_responder.sv | 122 ++++++++++++
 1 files changed

// File: rtl/dm_responder.sv
// Data-memory responder: accepts single-word read/write requests in IDLE, inserts
// WAIT wait states, then answers with a one-cycle ack (err for out-of-range addresses).
module dm_responder #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 256,
  parameter int unsigned WAIT   = 2
) (
  input  logic              clk,
  input  logic              rst_f,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              busy,
  output logic              ack,
  output logic              err,
  output logic [DATA_W-1:0] rdata
);

  localparam int unsigned     IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_L  = (ADDR_W + 1)'(DEPTH);
  localparam logic [3:0]      CNT_INIT = (WAIT > 0) ? 4'(WAIT - 1) : 4'd0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t              state, state_nxt;
  logic [3:0]          cnt, cnt_nxt;
  logic                accept;
  logic                enter_resp;
  logic                we_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic                cur_we;
  logic [ADDR_W-1:0]   cur_addr;
  logic [DATA_W-1:0]   cur_wdata;
  logic                in_range;
  logic [IDX_W-1:0]    idx;
  logic [DATA_W-1:0]   mem [DEPTH];

  // With WAIT=0 the response is committed on the acceptance edge itself, so the
  // request comes straight from the ports while idle and from the latches otherwise.
  always_comb begin
    cur_we    = (state == S_IDLE) ? we    : we_q;
    cur_addr  = (state == S_IDLE) ? addr  : addr_q;
    cur_wdata = (state == S_IDLE) ? wdata : wdata_q;
    in_range  = {1'b0, cur_addr} < DEPTH_L;
    idx       = cur_addr[IDX_W-1:0];
  end

  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    accept     = 1'b0;
    case (state)
      S_IDLE: begin
        if (req) begin
          accept = 1'b1;
          if (WAIT == 0) begin
            state_nxt = S_RESP;
            cnt_nxt   = '0;
          end else begin
            state_nxt = S_WAIT;
            cnt_nxt   = CNT_INIT;
          end
        end
      end
      S_WAIT: begin
        if (cnt == '0) state_nxt = S_RESP;
        else           cnt_nxt   = cnt - 4'd1;
      end
      S_RESP:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    enter_resp = (state_nxt == S_RESP);
  end

  assign busy = (state != S_IDLE);

  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      ack     <= 1'b0;
      err     <= 1'b0;
      rdata   <= '0;
    end else begin
      if (accept) begin
        we_q    <= we;
        addr_q  <= addr;
        wdata_q <= wdata;
      end
      ack <= enter_resp;
      err <= enter_resp && !in_range;
      if (enter_resp) begin
        if (!in_range)    rdata <= '0;
        else if (!cur_we) rdata <= mem[idx];
      end
    end
  end

  // Storage is deliberately not reset; a reset before this edge suppresses the write.
  always_ff @(posedge clk) begin
    if (enter_resp && cur_we && in_range) mem[idx] <= cur_wdata;
  end

endmodule
